// File: rtl/rv32_pkg.sv
// Shared definitions for the multi-cycle RV32I sequencer: opcodes, FSM states,
// writeback selects and the opcode legality check used in DECODE.
package rv32_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM,
        ST_WRITEBACK,
        ST_TRAP
    } ctrl_state_t;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_RSVD = 2'b11
    } wb_sel_t;

    function automatic logic opcode_legal(input logic [6:0] opc);
        case (opc)
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_LOAD,
            OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_timeout.sv
// Memory wait watchdog: reloads while no request is stalled, counts down while
// one is, and flags EXPIRED once MEM_TIMEOUT stalled cycles have elapsed.
module ctrl_timeout #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic expired
);
    localparam int unsigned    CW       = $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0]  LOAD_VAL = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= LOAD_VAL;
        else if (load)
            cnt <= LOAD_VAL;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with memory
// handshakes. RETIRE pulses in the first cycle the updated PC is visible.
module multicycle_controller
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        IMEM_REQ,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_RDATA,
    output logic        DMEM_REQ,
    output logic        DMEM_WE,
    output logic [31:0] DMEM_ADDR,
    input  logic        DMEM_ACK,
    output logic [31:0] PC,
    output logic [31:0] INSTR,
    input  logic [31:0] ALU_RESULT,
    input  logic        BR_TAKEN,
    output logic        RF_WE,
    output logic [1:0]  WB_SEL,
    output logic        RETIRE,
    output logic        TRAP
);
    ctrl_state_t state;
    wb_sel_t     wb_sel;
    logic [31:0] target_q;
    logic [31:0] pc_plus4;
    logic [31:0] exec_pc;
    logic [6:0]  opc;
    logic        rd_nz;
    logic        waiting;
    logic        tmo_expired;
    logic        go_trap;

    assign opc      = INSTR[6:0];
    assign rd_nz    = (INSTR[11:7] != 5'd0);
    assign pc_plus4 = PC + 32'd4;
    assign WB_SEL   = wb_sel;

    // Only one request is ever outstanding, so a single watchdog serves both.
    assign waiting = (IMEM_REQ && !IMEM_ACK) || (DMEM_REQ && !DMEM_ACK);

    ctrl_timeout #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
        .clk     (CLK),
        .rst     (RESET),
        .load    (!waiting),
        .dec     (waiting),
        .expired (tmo_expired)
    );

    always_comb begin
        exec_pc = pc_plus4;
        case (opc)
            OPC_BRANCH: exec_pc = BR_TAKEN ? ALU_RESULT : pc_plus4;
            OPC_JAL:    exec_pc = ALU_RESULT;
            OPC_JALR:   exec_pc = {ALU_RESULT[31:1], 1'b0};
            default:    exec_pc = pc_plus4;
        endcase
    end

    // Every next PC is resolved in EXECUTE, so alignment is only checked there.
    always_comb begin
        go_trap = 1'b0;
        case (state)
            ST_FETCH:   go_trap = IMEM_REQ && !IMEM_ACK && tmo_expired;
            ST_DECODE:  go_trap = !opcode_legal(opc);
            ST_EXECUTE: go_trap = (exec_pc[1:0] != 2'b00);
            ST_MEM:     go_trap = DMEM_REQ && !DMEM_ACK && tmo_expired;
            default:    go_trap = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= ST_FETCH;
            PC        <= RESET_PC;
            INSTR     <= '0;
            IMEM_REQ  <= 1'b0;
            DMEM_REQ  <= 1'b0;
            DMEM_WE   <= 1'b0;
            DMEM_ADDR <= '0;
            RF_WE     <= 1'b0;
            wb_sel    <= WB_ALU;
            RETIRE    <= 1'b0;
            TRAP      <= 1'b0;
            target_q  <= '0;
        end else begin
            RF_WE  <= 1'b0;
            RETIRE <= 1'b0;
            if (go_trap) begin
                state    <= ST_TRAP;
                TRAP     <= 1'b1;
                IMEM_REQ <= 1'b0;
                DMEM_REQ <= 1'b0;
                DMEM_WE  <= 1'b0;
            end else begin
                case (state)
                    ST_FETCH: begin
                        if (!IMEM_REQ) begin
                            IMEM_REQ <= 1'b1;
                        end else if (IMEM_ACK) begin
                            INSTR    <= IMEM_RDATA;
                            IMEM_REQ <= 1'b0;
                            state    <= ST_DECODE;
                        end
                    end
                    ST_DECODE: state <= ST_EXECUTE;
                    ST_EXECUTE: begin
                        target_q <= exec_pc;
                        case (opc)
                            OPC_LOAD, OPC_STORE: begin
                                DMEM_ADDR <= ALU_RESULT;
                                DMEM_REQ  <= 1'b1;
                                DMEM_WE   <= (opc == OPC_STORE);
                                state     <= ST_MEM;
                            end
                            OPC_BRANCH: begin
                                PC       <= exec_pc;
                                RETIRE   <= 1'b1;
                                IMEM_REQ <= 1'b1;
                                state    <= ST_FETCH;
                            end
                            OPC_JAL, OPC_JALR: begin
                                wb_sel <= WB_PC4;
                                RF_WE  <= rd_nz;
                                state  <= ST_WRITEBACK;
                            end
                            default: begin
                                wb_sel <= WB_ALU;
                                RF_WE  <= rd_nz;
                                state  <= ST_WRITEBACK;
                            end
                        endcase
                    end
                    ST_MEM: begin
                        if (DMEM_REQ && DMEM_ACK) begin
                            DMEM_REQ <= 1'b0;
                            DMEM_WE  <= 1'b0;
                            if (DMEM_WE) begin
                                PC       <= target_q;
                                RETIRE   <= 1'b1;
                                IMEM_REQ <= 1'b1;
                                state    <= ST_FETCH;
                            end else begin
                                wb_sel <= WB_LOAD;
                                RF_WE  <= rd_nz;
                                state  <= ST_WRITEBACK;
                            end
                        end
                    end
                    ST_WRITEBACK: begin
                        PC       <= target_q;
                        RETIRE   <= 1'b1;
                        IMEM_REQ <= 1'b1;
                        state    <= ST_FETCH;
                    end
                    default: state <= ST_TRAP;
                endcase
            end
        end
    end

endmodule
